// File: rtl/lowampa_capture_ctrl_pkg.sv
// Shared types and sample helpers for the low-amplitude-A capture sequencer.
package lowampa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int BEAT_BITS     = 64;
    localparam int SAMP_BITS     = 12;
    localparam int SAMP_PER_BEAT = 4;

    // Each 16-bit lane carries a 12-bit sample in its upper bits.
    function automatic logic [SAMP_BITS-1:0] unpack_samp(input logic [BEAT_BITS-1:0] beat,
                                                          input int i);
        return beat[16*i+4 +: SAMP_BITS];
    endfunction

endpackage

// File: rtl/lowampa_capture_ctrl_if.sv
// AXI4-Stream link from the capture sequencer to the capture buffer.
interface lowampa_capture_ctrl_if;
    // tvalid qualifies tdata/tlast; a beat transfers on an edge with tvalid & tready.
    // The upstream sources cannot stall, so tvalid is never held for tready: a beat
    // presented while tready is low is dropped and the master moves on next edge.
    logic [63:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/lowampa_capture_ctrl_thresh_detect.sv
// Self-trigger detector: hit when any signed 12-bit lane of a beat has |s| >= threshold.
module lowampa_thresh_detect
    import lowampa_pkg::*;
(
    input  logic [BEAT_BITS-1:0] i_beat,
    input  logic [SAMP_BITS-1:0] i_thresh,
    output logic                 o_hit
);

    logic [SAMP_PER_BEAT-1:0] w_lane_hit;
    logic                     w_unused_pad;

    for (genvar g = 0; g < SAMP_PER_BEAT; g++) begin : g_lane
        logic [SAMP_BITS-1:0] w_s;
        logic [SAMP_BITS-1:0] w_mag;

        // -2048 has no positive 12-bit twin, so its magnitude saturates to 2047.
        always_comb begin
            w_s = unpack_samp(i_beat, g);
            if (!w_s[SAMP_BITS-1]) begin
                w_mag = w_s;
            end else if (w_s == {1'b1, {(SAMP_BITS-1){1'b0}}}) begin
                w_mag = {1'b0, {(SAMP_BITS-1){1'b1}}};
            end else begin
                w_mag = -w_s;
            end
        end

        assign w_lane_hit[g] = (w_mag >= i_thresh);
    end

    assign w_unused_pad = ^{i_beat[3:0], i_beat[19:16], i_beat[35:32], i_beat[51:48]};
    assign o_hit        = (i_thresh != '0) && (|w_lane_hit);

endmodule

// File: rtl/lowampa_capture_ctrl.sv
// Capture sequencer: arm, wait for trigger, emit exactly LEN beats of the selected stream.
// Optional self-trigger on sample magnitude is built when LOWAMPA_THRESH_TRIG_EN is defined.
module lowampa_capture_ctrl
    import lowampa_pkg::*;
#(
    parameter int NSRC = 8,
    parameter int LENW = 16
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NSRC*64-1:0]        src_tdata,
    input  logic [NSRC-1:0]           src_tvalid,
    input  logic [$clog2(NSRC)-1:0]   sel_i,
    input  logic [LENW-1:0]           len_i,
    input  logic                      arm_i,
    input  logic                      abort_i,
    input  logic                      trig_i,
    input  logic [SAMP_BITS-1:0]      thresh_i,
    lowampa_capture_ctrl_if.master    m,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      overflow_o,
    output state_t                    o_dbg_state
);

    localparam int SELW = $clog2(NSRC);

    state_t                 r_state;
    logic [SELW-1:0]        r_sel;
    logic [LENW-1:0]        r_len;
    logic [LENW-1:0]        r_cnt;
    logic [BEAT_BITS-1:0]   r_tdata;
    logic                   r_tvalid;
    logic                   r_tlast;
    logic                   r_done;
    logic                   r_ovf;

    logic [BEAT_BITS-1:0]   w_src_beat;
    logic                   w_src_valid;
    logic                   w_trig;
    logic                   w_take;
    logic [LENW-1:0]        w_cnt_nxt;

    assign w_src_beat  = src_tdata[64*r_sel +: 64];
    assign w_src_valid = src_tvalid[r_sel];

`ifdef LOWAMPA_THRESH_TRIG_EN
    logic w_self_hit;

    lowampa_thresh_detect u_thresh_detect (
        .i_beat   (w_src_beat),
        .i_thresh (thresh_i),
        .o_hit    (w_self_hit)
    );

    assign w_trig = trig_i | w_self_hit;
`else
    logic w_unused_thresh;

    assign w_unused_thresh = ^thresh_i;
    assign w_trig          = trig_i;
`endif

    // r_cnt counts issued beats; a sample is taken on the trigger edge and on every
    // CAPTURE edge until LEN beats have gone out (time-fixed length under backpressure).
    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_take    = ((r_state == ST_ARMED) && w_trig) ||
                       ((r_state == ST_CAPTURE) && (r_cnt != r_len));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= ST_IDLE;
            r_sel    <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (r_tvalid && !m.tready) begin
                r_ovf <= 1'b1;
            end
            if (abort_i) begin
                r_state  <= ST_IDLE;
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
                r_done   <= 1'b0;
            end else if (w_take) begin
                r_state  <= ST_CAPTURE;
                r_tdata  <= w_src_beat;
                r_tvalid <= w_src_valid;
                r_tlast  <= w_src_valid && (w_cnt_nxt == r_len);
                if (w_src_valid) begin
                    r_cnt <= w_cnt_nxt;
                end
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (arm_i && (len_i != '0)) begin
                            r_sel   <= sel_i;
                            r_len   <= len_i;
                            r_cnt   <= '0;
                            r_done  <= 1'b0;
                            r_ovf   <= 1'b0;
                            r_state <= ST_ARMED;
                        end
                    end
                    ST_CAPTURE: begin
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign m.tdata     = r_tdata;
    assign m.tvalid    = r_tvalid;
    assign m.tlast     = r_tlast;
    assign busy_o      = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
    assign done_o      = r_done;
    assign overflow_o  = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lowampa_capture_ctrl.sv
// Directed bench for lowampa_capture_ctrl with a behavioural capture model and beat scoreboard.
module tb_lowampa_capture_ctrl;
    import lowampa_pkg::*;

    // ---------------- clock / reset / signals ----------------
    logic         aclk = 1'b0;
    logic         aresetn;
    logic [511:0] src_tdata  = '0;
    logic [7:0]   src_tvalid = 8'hFF;
    logic [2:0]   sel_i;
    logic [15:0]  len_i;
    logic         arm_i, abort_i, trig_i;
    logic [11:0]  thresh_i;
    logic         busy_o, done_o, overflow_o;
    state_t       dbg_state;

    lowampa_capture_ctrl_if m_if ();

    lowampa_capture_ctrl #(.NSRC(8), .LENW(16)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .src_tdata   (src_tdata),
        .src_tvalid  (src_tvalid),
        .sel_i       (sel_i),
        .len_i       (len_i),
        .arm_i       (arm_i),
        .abort_i     (abort_i),
        .trig_i      (trig_i),
        .thresh_i    (thresh_i),
        .m           (m_if),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overflow_o  (overflow_o),
        .o_dbg_state (dbg_state)
    );

    initial forever #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- free-running sources ----------------
    // Source n at bench cycle c: {n, c, c*7+n}; source 7 can be forced to a quiet/injected beat.
    int          cyc = 0;
    logic [7:0]  vmask = 8'hFF;
    logic        quiet = 1'b0;
    logic [63:0] quiet_data = '0;

    initial forever begin
        @(negedge aclk);
        #1;
        cyc++;
        for (int n = 0; n < 8; n++) begin
            if (quiet && n == 7) src_tdata[64*n +: 64] = quiet_data;
            else                 src_tdata[64*n +: 64] = {8'(n), 24'(cyc), 32'(cyc * 7 + n)};
        end
        src_tvalid = vmask;
    end

    // ---------------- behavioural model ----------------
    logic [64:0] exp_q[$];
    int          m_mode = 0;   // 0 idle, 1 waiting for trigger, 2 capturing, 3 finished
    int          m_len = 0, m_sel = 0, m_issued = 0;
    bit          m_valid = 0, m_last = 0, m_done = 0, m_ovf = 0;
    logic [63:0] m_beat;

    function automatic bit self_hit(input logic [63:0] b, input logic [11:0] th);
        bit hit = 0;
`ifdef LOWAMPA_THRESH_TRIG_EN
        for (int i = 0; i < 4; i++) begin
            int s, mag;
            s   = $signed(b[16*i+4 +: 12]);
            mag = (s < 0) ? -s : s;
            if (mag > 2047) mag = 2047;
            if (th != 0 && mag >= int'(th)) hit = 1;
        end
`else
        hit = (b === 64'hx) && (th === 12'hx);
`endif
        return hit;
    endfunction

    task automatic model_take();
        m_beat  = src_tdata[64*m_sel +: 64];
        m_valid = src_tvalid[m_sel];
        m_mode  = 2;
        if (m_valid) begin
            m_issued++;
            m_last = (m_issued == m_len);
            exp_q.push_back({m_last, m_beat});
        end else begin
            m_last = 0;
        end
    endtask

    initial forever begin
        @(posedge aclk or negedge aresetn);
        if (!aresetn) begin
            m_mode = 0; m_valid = 0; m_last = 0; m_done = 0; m_ovf = 0;
        end else begin
            if (m_valid && !m_if.tready) m_ovf = 1;
            if (abort_i) begin
                m_mode = 0; m_valid = 0; m_last = 0; m_done = 0;
            end else begin
                case (m_mode)
                    0, 3: if (arm_i && len_i != 0) begin
                        m_sel = int'(sel_i); m_len = int'(len_i); m_issued = 0;
                        m_done = 0; m_ovf = 0; m_mode = 1;
                    end
                    1: if (trig_i || self_hit(src_tdata[64*m_sel +: 64], thresh_i)) model_take();
                    default: if (m_issued == m_len) begin
                        m_valid = 0; m_last = 0; m_done = 1; m_mode = 3;
                    end else begin
                        model_take();
                    end
                endcase
            end
        end
    end

    // ---------------- compare process / scoreboard ----------------
    int          rd_idx = 0;
    int          obs_issued = 0, obs_acc = 0, obs_last = 0;
    int          mark = 0;
    logic [63:0] first_data = '0, last_data = '0;

    initial forever begin
        @(negedge aclk);
        if (!aresetn) begin
            rd_idx = exp_q.size();
        end else begin
            chk("tvalid", m_if.tvalid, m_valid);
            chk("tlast", m_if.tlast, m_last);
            chk("busy", busy_o, (m_mode == 1 || m_mode == 2));
            chk("done", done_o, m_done);
            chk("overflow", overflow_o, m_ovf);
            if (m_if.tvalid) begin
                obs_issued++;
                if (m_if.tready) obs_acc++;
                if (m_if.tlast)  obs_last++;
                if (obs_issued == mark + 1) first_data = m_if.tdata;
                last_data = m_if.tdata;
                if (rd_idx >= exp_q.size()) begin
                    chk("beat_extra", 65'(rd_idx), 65'(exp_q.size()));
                end else begin
                    chk("beat", {m_if.tlast, m_if.tdata}, exp_q[rd_idx]);
                    rd_idx++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_arm(input int s, input int l);
        sel_i = 3'(s); len_i = 16'(l); arm_i = 1'b1;
        @(negedge aclk);
        arm_i = 1'b0;
    endtask

    task automatic pulse_trig();
        trig_i = 1'b1;
        @(negedge aclk);
        trig_i = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string name);
        int k = 0;
        while (!done_o && k < maxc) begin
            @(negedge aclk);
            k++;
        end
        #2;
        chk(name, done_o, 1'b1);
    endtask

    int base_last, base_acc;

    initial begin
        aresetn = 1'b0; arm_i = 0; abort_i = 0; trig_i = 0;
        sel_i = '0; len_i = '0; thresh_i = '0; m_if.tready = 1'b1;
        repeat (3) @(negedge aclk);
        #2;
        chk("rst_tvalid", m_if.tvalid, 1'b0);
        chk("rst_tlast", m_if.tlast, 1'b0);
        chk("rst_tdata", m_if.tdata, 64'h0);
        chk("rst_flags", {busy_o, done_o, overflow_o}, 3'b000);
        chk("rst_state", 65'(dbg_state), 65'(ST_IDLE));
        @(negedge aclk);
        #3 aresetn = 1'b1;
        @(negedge aclk);

        // sel=2 len=4, trigger five cycles after arm
        mark = obs_issued; base_last = obs_last;
        pulse_arm(2, 4);
        repeat (4) @(negedge aclk);
        pulse_trig();
        wait_done(20, "t1_done");
        chk("t1_beats", 65'(obs_issued - mark), 65'd4);
        chk("t1_tlast_cnt", 65'(obs_last - base_last), 65'd1);
        chk("t1_src_id", first_data[63:56], 8'd2);
        chk("t1_consecutive", 65'(last_data[55:32] - first_data[55:32]), 65'd3);
        chk("t1_busy", busy_o, 1'b0);

        // len=1: single beat carrying tlast
        mark = obs_issued; base_last = obs_last;
        pulse_arm(5, 1);
        @(negedge aclk);
        pulse_trig();
        wait_done(20, "t2_done");
        chk("t2_beats", 65'(obs_issued - mark), 65'd1);
        chk("t2_tlast_cnt", 65'(obs_last - base_last), 65'd1);
        chk("t2_src_id", first_data[63:56], 8'd5);

        // len=0 arm is ignored
        pulse_arm(1, 0);
        repeat (3) @(negedge aclk);
        #2;
        chk("t2_len0_busy", busy_o, 1'b0);
        chk("t2_len0_done", done_o, 1'b1);

        // arm and trigger in the same cycle: arm only
        mark = obs_issued;
        sel_i = 3'd1; len_i = 16'd2; arm_i = 1'b1; trig_i = 1'b1;
        @(negedge aclk);
        arm_i = 1'b0; trig_i = 1'b0;
        repeat (3) @(negedge aclk);
        #2;
        chk("t2b_armed_busy", busy_o, 1'b1);
        chk("t2b_no_beats", 65'(obs_issued - mark), 65'd0);
        @(negedge aclk);
        pulse_trig();
        wait_done(20, "t2b_done");
        chk("t2b_beats", 65'(obs_issued - mark), 65'd2);

        // tready low on beat 2 of 8
        mark = obs_issued; base_acc = obs_acc; base_last = obs_last;
        pulse_arm(3, 8);
        trig_i = 1'b1;
        @(negedge aclk);
        trig_i = 1'b0;
        @(negedge aclk);
        m_if.tready = 1'b0;
        @(negedge aclk);
        m_if.tready = 1'b1;
        wait_done(30, "t3_done");
        chk("t3_beats", 65'(obs_issued - mark), 65'd8);
        chk("t3_accepted", 65'(obs_acc - base_acc), 65'd7);
        chk("t3_tlast_cnt", 65'(obs_last - base_last), 65'd1);
        chk("t3_overflow", overflow_o, 1'b1);
        mark = obs_issued;
        pulse_arm(3, 2);
        #2;
        chk("t3_ovf_cleared", overflow_o, 1'b0);
        pulse_trig();
        wait_done(20, "t3b_done");
        chk("t3b_overflow", overflow_o, 1'b0);

        // abort at beat 3
        mark = obs_issued; base_last = obs_last;
        pulse_arm(4, 6);
        trig_i = 1'b1;
        @(negedge aclk);
        trig_i = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        abort_i = 1'b1;
        @(negedge aclk);
        abort_i = 1'b0;
        #2;
        chk("t4_tvalid", m_if.tvalid, 1'b0);
        chk("t4_tlast", m_if.tlast, 1'b0);
        chk("t4_flags", {busy_o, done_o}, 2'b00);
        chk("t4_beats", 65'(obs_issued - mark), 65'd3);
        chk("t4_tlast_cnt", 65'(obs_last - base_last), 65'd0);
        chk("t4_state", 65'(dbg_state), 65'(ST_IDLE));

        // src_tvalid gap of two cycles mid-capture
        @(negedge aclk);
        mark = obs_issued; base_last = obs_last;
        pulse_arm(6, 5);
        trig_i = 1'b1;
        @(negedge aclk);
        trig_i = 1'b0;
        @(negedge aclk);
        vmask[6] = 1'b0;
        repeat (2) @(negedge aclk);
        vmask[6] = 1'b1;
        wait_done(30, "t5_done");
        chk("t5_beats", 65'(obs_issued - mark), 65'd5);
        chk("t5_tlast_cnt", 65'(obs_last - base_last), 65'd1);
        chk("t5_span", 65'(last_data[55:32] - first_data[55:32]), 65'd6);

        // asynchronous reset mid-capture
        mark = obs_issued; base_last = obs_last;
        pulse_arm(0, 10);
        pulse_trig();
        repeat (2) @(negedge aclk);
        #2 aresetn = 1'b0;
        #1;
        chk("t6_tvalid", m_if.tvalid, 1'b0);
        chk("t6_tdata", m_if.tdata, 64'h0);
        chk("t6_flags", {m_if.tlast, busy_o, done_o, overflow_o}, 4'b0000);
        chk("t6_no_tlast", 65'(obs_last - base_last), 65'd0);
        @(negedge aclk);
        #3 aresetn = 1'b1;
        @(negedge aclk);

`ifdef LOWAMPA_THRESH_TRIG_EN
        // self-trigger: -99 stays below 100, -150 in lane 3 starts the capture
        quiet = 1'b1; quiet_data = '0; thresh_i = 12'd100;
        @(negedge aclk);
        mark = obs_issued;
        pulse_arm(7, 3);
        repeat (2) @(negedge aclk);
        quiet_data = {12'hF9D, 52'h0};
        @(negedge aclk);
        quiet_data = '0;
        repeat (2) @(negedge aclk);
        #2;
        chk("t7_armed_busy", busy_o, 1'b1);
        chk("t7_no_early_beat", 65'(obs_issued - mark), 65'd0);
        @(negedge aclk);
        quiet_data = {12'hF6A, 52'h0};
        @(negedge aclk);
        quiet_data = '0;
        wait_done(20, "t7_done");
        chk("t7_beats", 65'(obs_issued - mark), 65'd3);
        chk("t7_first_beat", first_data, 64'hF6A0_0000_0000_0000);
        thresh_i = '0; quiet = 1'b0;
`endif

        repeat (2) @(negedge aclk);
        #2;
        chk("beats_drained", 65'(rd_idx), 65'(exp_q.size()));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
